mem_arbiter: RTL and testbench

- Shares the core's single Wishbone master port between the instruction-fetch port (IF stage) and the data port (load/store unit).
- Sequences one bus transaction at a time and returns data, ready and error to the requester that owns the bus.
- Arbitrates round-robin when both ports request in the same cycle.
- A timeout counter converts a hung slave into an error, and a fetch flush discards any in-flight instruction response.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin Wishbone master arbiter between instruction-fetch and load/store ports
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] iport_addr_i,
    input  logic        iport_req_i,
    input  logic        iport_flush_i,
    output logic [31:0] iport_data_o,
    output logic        iport_ready_o,
    output logic        iport_err_o,

    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_data_i,
    input  logic [3:0]  dport_sel_i,
    input  logic        dport_we_i,
    input  logic        dport_req_i,
    output logic [31:0] dport_data_o,
    output logic        dport_ready_o,
    output logic        dport_err_o,

    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // Last counter value of a bus cycle before a silent slave is treated as hung.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_d;   // 1: data port owned the bus most recently
    logic        r_discard;  // fetch response of the current IBUS cycle must be dropped
    logic        r_settle;   // response cycle: no new grant while the pulse is out
    logic [7:0]  r_cnt;

    logic w_grant_i;
    logic w_grant_d;
    logic w_end;
    logic w_fail;
    logic w_drop;

    // On contention the port that did not win last time gets the bus.
    assign w_grant_d = dport_req_i & (~iport_req_i | ~r_last_d);
    assign w_grant_i = iport_req_i & (~dport_req_i | r_last_d);

    // A bus cycle ends on ack, on err, or when the slave has been silent too long.
    // An end without ack (or with err alongside ack) is reported as an error.
    assign w_end  = wbm_ack_i | wbm_err_i | (r_cnt == TO_LAST);
    assign w_fail = wbm_err_i | ~wbm_ack_i;
    // A flush arriving in the very cycle the fetch completes still discards it.
    assign w_drop = r_discard | iport_flush_i;

    // Arbitration FSM with registered bus and requester outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_last_d      <= 1'b1;
            r_discard     <= 1'b0;
            r_settle      <= 1'b0;
            r_cnt         <= 8'd0;
            iport_data_o  <= 32'd0;
            iport_ready_o <= 1'b0;
            iport_err_o   <= 1'b0;
            dport_data_o  <= 32'd0;
            dport_ready_o <= 1'b0;
            dport_err_o   <= 1'b0;
            wbm_addr_o    <= 32'd0;
            wbm_dat_o     <= 32'd0;
            wbm_sel_o     <= 4'd0;
            wbm_we_o      <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
        end else begin
            iport_ready_o <= 1'b0;
            iport_err_o   <= 1'b0;
            dport_ready_o <= 1'b0;
            dport_err_o   <= 1'b0;
            r_settle      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= 8'd0;
                    r_discard <= 1'b0;
                    if (!r_settle) begin
                        if (w_grant_d) begin
                            wbm_addr_o <= dport_addr_i;
                            wbm_dat_o  <= dport_data_i;
                            wbm_sel_o  <= dport_sel_i;
                            wbm_we_o   <= dport_we_i;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            r_last_d   <= 1'b1;
                            r_state    <= ST_DBUS;
                        end else if (w_grant_i) begin
                            wbm_addr_o <= iport_addr_i;
                            wbm_dat_o  <= 32'd0;
                            wbm_sel_o  <= 4'hF;
                            wbm_we_o   <= 1'b0;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            r_last_d   <= 1'b0;
                            r_state    <= ST_IBUS;
                        end
                    end
                end

                ST_IBUS: begin
                    if (w_end) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_discard <= 1'b0;
                        r_settle  <= 1'b1;
                        r_state   <= ST_IDLE;
                        if (!w_drop) begin
                            if (w_fail) begin
                                iport_err_o <= 1'b1;
                            end else begin
                                iport_ready_o <= 1'b1;
                                iport_data_o  <= wbm_dat_i;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (iport_flush_i) begin
                            r_discard <= 1'b1;
                        end
                    end
                end

                ST_DBUS: begin
                    if (w_end) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_settle  <= 1'b1;
                        r_state   <= ST_IDLE;
                        if (w_fail) begin
                            dport_err_o <= 1'b1;
                        end else begin
                            dport_ready_o <= 1'b1;
                            dport_data_o  <= wbm_dat_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - transaction-level self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] iport_addr_i = '0;
    logic        iport_req_i = 1'b0;
    logic        iport_flush_i = 1'b0;
    logic [31:0] iport_data_o;
    logic        iport_ready_o;
    logic        iport_err_o;
    logic [31:0] dport_addr_i = '0;
    logic [31:0] dport_data_i = '0;
    logic [3:0]  dport_sel_i = '0;
    logic        dport_we_i = 1'b0;
    logic        dport_req_i = 1'b0;
    logic [31:0] dport_data_o;
    logic        dport_ready_o;
    logic        dport_err_o;
    logic [31:0] wbm_addr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iport_addr_i(iport_addr_i), .iport_req_i(iport_req_i), .iport_flush_i(iport_flush_i),
        .iport_data_o(iport_data_o), .iport_ready_o(iport_ready_o), .iport_err_o(iport_err_o),
        .dport_addr_i(dport_addr_i), .dport_data_i(dport_data_i), .dport_sel_i(dport_sel_i),
        .dport_we_i(dport_we_i), .dport_req_i(dport_req_i), .dport_data_o(dport_data_o),
        .dport_ready_o(dport_ready_o), .dport_err_o(dport_err_o),
        .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Transaction plan: each grant is resolved up front into its bus length and outcome.
    int          t = 0;
    bit          rnd_mode = 0;
    bit          hold_both = 0;
    int          f_w = 0;
    int          f_flush_off = -1;
    logic [31:0] f_rdata = '0;

    int          m_owner = 0;      // 0 none, 1 fetch, 2 data
    bit          m_last_d = 1;
    int          m_t0, m_len, m_resp, m_w, m_flush_at;
    int          m_free = 0;
    bit          m_errf, m_ackerr, m_kerr, m_disc;
    logic [31:0] m_rdata, m_addr, m_dat;
    logic [3:0]  m_sel;
    bit          m_we;
    logic [31:0] m_idata = '0;
    logic [31:0] m_ddata = '0;

    int glog[$];
    bit prev_cyc = 0;
    int cnt_cyc, cnt_iready, cnt_ierr, cnt_dready, cnt_derr, cnt_ack;

    task automatic new_ireq();
        iport_addr_i = $urandom & 32'hFFFF_FFFC;
        iport_req_i  = 1'b1;
    endtask

    task automatic new_dreq();
        dport_addr_i = $urandom;
        dport_data_i = $urandom;
        dport_sel_i  = 4'($urandom);
        dport_we_i   = 1'($urandom);
        dport_req_i  = 1'b1;
    endtask

    task automatic sample();
        bit ecyc, pulse, e_ir, e_ie, e_dr, e_de;
        @(negedge clk_i);
        t++;
        ecyc  = (m_owner != 0) && (t >= m_t0) && (t < m_t0 + m_len);
        pulse = (m_owner != 0) && (t == m_resp);
        e_ir = 0; e_ie = 0; e_dr = 0; e_de = 0;
        if (pulse && !m_disc) begin
            if (m_owner == 1) begin
                if (m_kerr) e_ie = 1;
                else begin e_ir = 1; m_idata = m_rdata; end
            end else begin
                if (m_kerr) e_de = 1;
                else begin e_dr = 1; m_ddata = m_rdata; end
            end
        end
        check("cyc", 32'(wbm_cyc_o), 32'(ecyc));
        check("stb", 32'(wbm_stb_o), 32'(ecyc));
        check("iport_ready", 32'(iport_ready_o), 32'(e_ir));
        check("iport_err", 32'(iport_err_o), 32'(e_ie));
        check("dport_ready", 32'(dport_ready_o), 32'(e_dr));
        check("dport_err", 32'(dport_err_o), 32'(e_de));
        check("iport_data", iport_data_o, m_idata);
        check("dport_data", dport_data_o, m_ddata);
        if (ecyc) begin
            check("bus_addr", wbm_addr_o, m_addr);
            check("bus_wdata", wbm_dat_o, m_dat);
            check("bus_sel", 32'(wbm_sel_o), 32'(m_sel));
            check("bus_we", 32'(wbm_we_o), 32'(m_we));
        end
        if (wbm_cyc_o) cnt_cyc++;
        if (iport_ready_o) cnt_iready++;
        if (iport_err_o) cnt_ierr++;
        if (dport_ready_o) cnt_dready++;
        if (dport_err_o) cnt_derr++;
        if (wbm_cyc_o && !prev_cyc)
            glog.push_back(wbm_addr_o == 32'h300 ? 1 : (wbm_addr_o == 32'h400 ? 2 : 0));
        prev_cyc = wbm_cyc_o;

        if (pulse) begin
            if (m_owner == 1 && !m_disc) begin
                if (!hold_both) iport_req_i = 1'b0;
                if (rnd_mode && ($urandom % 2 == 0)) new_ireq();
            end
            if (m_owner == 2) begin
                if (!hold_both) dport_req_i = 1'b0;
                if (rnd_mode && ($urandom % 2 == 0)) new_dreq();
            end
            m_owner = 0;
        end
        iport_flush_i = 1'b0;
        if (m_owner == 1 && t == m_flush_at) begin
            iport_flush_i = 1'b1;
            iport_req_i   = 1'b0;
        end else if (rnd_mode && m_owner != 1 && ($urandom % 8 == 0)) begin
            iport_flush_i = 1'b1;
        end
        if (rnd_mode) begin
            if (!iport_req_i && ($urandom % 4 == 0)) new_ireq();
            if (!dport_req_i && ($urandom % 4 == 0)) new_dreq();
        end
    endtask

    task automatic drive();
        int r;
        if (m_owner == 0 && t >= m_free && (iport_req_i || dport_req_i)) begin
            if (iport_req_i && dport_req_i) m_owner = m_last_d ? 1 : 2;
            else                            m_owner = iport_req_i ? 1 : 2;
            m_last_d = (m_owner == 2);
            if (m_owner == 1) begin
                m_addr = iport_addr_i; m_dat = '0; m_sel = 4'hF; m_we = 0;
            end else begin
                m_addr = dport_addr_i; m_dat = dport_data_i; m_sel = dport_sel_i; m_we = dport_we_i;
            end
            if (!rnd_mode) m_w = f_w;
            else begin
                r = int'($urandom % 12);
                m_w = (r == 0) ? TO + 2 : (r == 1) ? TO - 1 : int'($urandom % 4);
            end
            m_errf   = rnd_mode && ($urandom % 8 == 0);
            m_ackerr = 1'($urandom);
            m_rdata  = rnd_mode ? $urandom : f_rdata;
            m_t0     = t + 1;
            m_len    = (m_w < TO) ? m_w + 1 : TO;
            m_kerr   = m_errf || (m_w >= TO);
            m_resp   = m_t0 + m_len;
            m_free   = m_resp + 1;
            m_flush_at = -1;
            if (m_owner == 1) begin
                if (f_flush_off >= 0) m_flush_at = m_t0 + (f_flush_off % m_len);
                else if (rnd_mode && ($urandom % 5 == 0)) m_flush_at = m_t0 + int'($urandom % m_len);
            end
            m_disc = (m_flush_at >= 0);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
        if (m_owner != 0 && t >= m_t0 && t < m_t0 + m_len && (t - m_t0) == m_w) begin
            wbm_dat_i = m_rdata;
            if (m_errf) begin
                wbm_err_i = 1'b1;
                wbm_ack_i = m_ackerr;
            end else begin
                wbm_ack_i = 1'b1;
            end
        end
        if (wbm_ack_i && wbm_cyc_o) cnt_ack++;
    endtask

    task automatic cycle();
        sample();
        drive();
    endtask

    task automatic drain();
        int n = 0;
        while ((iport_req_i || dport_req_i || m_owner != 0) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_bound", 32'(n >= 200), 32'd0);
    endtask

    task automatic both_req();
        iport_addr_i = 32'h300;
        iport_req_i  = 1'b1;
        dport_addr_i = 32'h400;
        dport_data_i = 32'h0;
        dport_sel_i  = 4'hF;
        dport_we_i   = 1'b0;
        dport_req_i  = 1'b1;
    endtask

    initial begin
        int lat;
        int n;
        repeat (2) @(negedge clk_i);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_addr", wbm_addr_o, 32'd0);
        check("rst_pulses", 32'({iport_ready_o, iport_err_o, dport_ready_o, dport_err_o}), 32'd0);
        check("rst_idata", iport_data_o, 32'd0);
        check("rst_ddata", dport_data_o, 32'd0);

        // Contention right after reset, then both held: I, D, I, D.
        f_w = 0; f_rdata = 32'h1111_2222;
        sample();
        rst_i = 1'b1;
        both_req();
        hold_both = 1;
        glog.delete();
        drive();
        n = 0;
        while (glog.size() < 4 && n < 100) begin cycle(); n++; end
        hold_both = 0;
        drain();
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'd0,
                  (i % 2 == 0) ? 32'd1 : 32'd2);

        // Zero-wait fetch: ready in the third cycle of the request.
        f_w = 0; f_rdata = 32'h0000_0013;
        sample();
        iport_addr_i = 32'h100; iport_req_i = 1'b1;
        drive();
        lat = 1;
        while (!iport_ready_o && lat < 8) begin cycle(); lat++; end
        check("fetch_latency", 32'(lat), 32'd3);
        check("fetch_data", iport_data_o, 32'h13);
        drain();

        // Store with partial byte lanes.
        f_w = 1; f_rdata = 32'h5555_0000;
        cnt_dready = 0;
        sample();
        dport_addr_i = 32'h2000_0004; dport_data_i = 32'hDEAD_BEEF;
        dport_sel_i = 4'b0011; dport_we_i = 1'b1; dport_req_i = 1'b1;
        drive();
        drain();
        check("store_ready_count", 32'(cnt_dready), 32'd1);
        check("store_iport_data", iport_data_o, 32'h13);

        // Silent slave: timeout after TO cycles, then a normal transfer.
        f_w = 100;
        cnt_cyc = 0; cnt_derr = 0;
        sample();
        dport_addr_i = 32'h3000_0000; dport_we_i = 1'b0; dport_sel_i = 4'hF; dport_req_i = 1'b1;
        drive();
        drain();
        check("timeout_cyc_cycles", 32'(cnt_cyc), 32'(TO));
        check("timeout_err_count", 32'(cnt_derr), 32'd1);
        f_w = 0; f_rdata = 32'hCAFE_0001;
        cnt_dready = 0;
        sample();
        dport_req_i = 1'b1;
        drive();
        drain();
        check("after_timeout_ready", 32'(cnt_dready), 32'd1);
        check("after_timeout_data", dport_data_o, 32'hCAFE_0001);

        // Flush during a 3-wait fetch: bus completes, response swallowed.
        f_w = 3; f_flush_off = 1; f_rdata = 32'h0000_0077;
        cnt_ack = 0; cnt_iready = 0; cnt_ierr = 0;
        sample();
        iport_addr_i = 32'h180; iport_req_i = 1'b1;
        drive();
        drain();
        f_flush_off = -1;
        check("flush_ack_count", 32'(cnt_ack), 32'd1);
        check("flush_ready_count", 32'(cnt_iready), 32'd0);
        check("flush_err_count", 32'(cnt_ierr), 32'd0);
        check("flush_data_kept", iport_data_o, 32'h13);
        f_w = 0; f_rdata = 32'h0200_0013;
        cnt_iready = 0;
        sample();
        iport_addr_i = 32'h200; iport_req_i = 1'b1;
        drive();
        drain();
        check("post_flush_ready", 32'(cnt_iready), 32'd1);
        check("post_flush_data", iport_data_o, 32'h0200_0013);

        // Asynchronous reset in the middle of a stalled data transfer.
        f_w = 100;
        sample();
        dport_addr_i = 32'h4000_0000; dport_we_i = 1'b0; dport_req_i = 1'b1;
        drive();
        repeat (3) cycle();
        #2 rst_i = 1'b0;
        #1;
        check("arst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("arst_stb", 32'(wbm_stb_o), 32'd0);
        check("arst_addr", wbm_addr_o, 32'd0);
        check("arst_ddata", dport_data_o, 32'd0);
        check("arst_idata", iport_data_o, 32'd0);
        m_owner = 0; m_last_d = 1; m_free = 0; m_idata = '0; m_ddata = '0;
        dport_req_i = 1'b0; iport_req_i = 1'b0;
        cnt_derr = 0; cnt_dready = 0;
        cycle();
        cycle();
        f_w = 0; f_rdata = 32'h0BAD_F00D;
        sample();
        rst_i = 1'b1;
        both_req();
        glog.delete();
        drive();
        drain();
        check("arst_no_dpulse", 32'(cnt_derr + cnt_dready - 1), 32'd0);
        check("arst_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'd0, 32'd1);

        // Randomized traffic with random waits, errors, timeouts and flushes.
        rnd_mode = 1;
        repeat (3000) cycle();
        rnd_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
